// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder, subtract the divisor, keep the difference if it did not go negative.
module mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);

    logic [WIDTH:0] part;
    logic [WIDTH:0] diff;

    assign part  = {rem, quo[WIDTH-1]};
    assign diff  = part - {1'b0, dvs};
    // diff[WIDTH] set means the trial subtraction borrowed: restore.
    assign rem_n = diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_n = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/mdu_iter.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring step per cycle.
// MDU_UNSIGNED_EN enables MULTU/DIVU; without it those encodings are ignored.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               is_div_q, q_neg, r_neg, div0_q;

    logic               is_signed, op_mul, op_div;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MDU_UNSIGNED_EN
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
`else
    assign is_signed = 1'b1;
    assign op_mul    = (op == OP_MULT);
    assign op_div    = (op == OP_DIV);
`endif

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide.
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_n, div_n, step_n, res;

    assign msum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc[0]}} & {1'b0, opb});
    assign mul_n = {msum, acc[WIDTH-1:1]};

    mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .rem   (acc[2*WIDTH-1:WIDTH]),
        .quo   (acc[WIDTH-1:0]),
        .dvs   (opb),
        .rem_n (div_n[2*WIDTH-1:WIDTH]),
        .quo_n (div_n[WIDTH-1:0])
    );

    assign step_n = is_div_q ? div_n : mul_n;

    // Sign fix-up; remainder follows the dividend, zero divisor forces LO to all ones.
    always_comb begin
        res = q_neg ? (~step_n + 1'b1) : step_n;
        if (is_div_q) begin
            res[WIDTH-1:0] = div0_q ? '1 :
                             (q_neg ? (~step_n[WIDTH-1:0] + 1'b1) : step_n[WIDTH-1:0]);
            res[2*WIDTH-1:WIDTH] = r_neg ? (~step_n[2*WIDTH-1:WIDTH] + 1'b1)
                                         : step_n[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            is_div_q <= 1'b0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div0_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div0     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            if (flush) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else if (state == S_CALC) begin
                acc <= step_n;
                cnt <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state    <= S_DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    div0     <= div0_q;
                    {hi, lo} <= res;
                end
            end else if (start && (op_mul || op_div)) begin
                state    <= S_CALC;
                busy     <= 1'b1;
                cnt      <= CW'(WIDTH);
                acc      <= {{WIDTH{1'b0}}, a_mag};
                opb      <= b_mag;
                is_div_q <= op_div;
                q_neg    <= a_neg ^ b_neg;
                r_neg    <= a_neg;
                div0_q   <= op_div && (b == '0);
            end else begin
                state <= S_IDLE;
                if (start && op == OP_MTHI) hi <= a;
                if (start && op == OP_MTLO) lo <= a;
            end
        end
    end

endmodule
